// File: rtl/mac_seq.sv
// Sequential signed fixed-point MAC: one tap per cycle through a single multiplier,
// then bias add, scale-down, saturation and optional ReLU.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// MAC   | accumulating tap k = 0..N-1
// FIN   | bias add, shift, saturate, ReLU, register result
// DONE  | result held until out_valid && out_ready

module mac_seq #(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int N    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_data,
    input  logic [N*DW-1:0]   in_weight,
    input  logic [DW-1:0]     in_bias,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_res,
    output logic              out_sat
);

    localparam int ACC_W = 2*DW + $clog2(N) + 1;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int SW    = ACC_W + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic signed [SW-1:0] MAX_V = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [N*DW-1:0]          data_r;
    logic [N*DW-1:0]          weight_r;
    logic [DW-1:0]            bias_r;
    logic                     relu_r;
    logic signed [ACC_W-1:0]  acc;
    logic [KW-1:0]            k;

    logic signed [DW-1:0]     tap_d;
    logic signed [DW-1:0]     tap_w;
    logic signed [2*DW-1:0]   d_ext;
    logic signed [2*DW-1:0]   w_ext;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_ext;

    logic signed [SW-1:0]     acc_ext;
    logic signed [SW-1:0]     bias_ext;
    logic signed [SW-1:0]     bias_sh;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     scaled;
    logic [DW-1:0]            res_nx;
    logic                     sat_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = MAC;
            end
            MAC: begin
                if (k == K_LAST) state_nx = FIN;
            end
            FIN: begin
                state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tap mux with constant slice indices keeps the select free of index arithmetic.
    always_comb begin
        tap_d = '0;
        tap_w = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                tap_d = data_r[i*DW +: DW];
                tap_w = weight_r[i*DW +: DW];
            end
        end
    end

    always_comb begin
        d_ext    = {{DW{tap_d[DW-1]}}, tap_d};
        w_ext    = {{DW{tap_w[DW-1]}}, tap_w};
        prod     = d_ext * w_ext;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end

    // Arithmetic shift truncates toward -inf; no rounding term is added.
    always_comb begin
        acc_ext  = {acc[ACC_W-1], acc};
        bias_ext = {{(SW-DW){bias_r[DW-1]}}, bias_r};
        bias_sh  = bias_ext <<< FRAC;
        sum      = acc_ext + bias_sh;
        scaled   = sum >>> FRAC;
        res_nx   = scaled[DW-1:0];
        sat_nx   = 1'b0;
        if (scaled > MAX_V) begin
            res_nx = MAX_V[DW-1:0];
            sat_nx = 1'b1;
        end else if (scaled < MIN_V) begin
            res_nx = MIN_V[DW-1:0];
            sat_nx = 1'b1;
        end
        if (relu_r && res_nx[DW-1]) begin
            res_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= '0;
            weight_r  <= '0;
            bias_r    <= '0;
            relu_r    <= 1'b0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r   <= in_data;
                        weight_r <= in_weight;
                        bias_r   <= in_bias;
                        relu_r   <= relu_en;
                        acc      <= '0;
                        k        <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k != K_LAST) k <= k + 1'b1;
                end
                FIN: begin
                    out_res   <= res_nx;
                    out_sat   <= sat_nx;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
